// File: rtl/param_inst_queue_if.sv
// Handshake bundle for param_inst_queue: producer/consumer request signals in, data and status out.
// Handshake rule: enqueue is taken when !full or when a same-cycle dequeue pops;
// dequeue is taken only when !empty. Neither request feeds back combinationally into status.
interface param_inst_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  enqueue;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  dequeue;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [CW-1:0]         count;
  logic                  ovf_err;
  logic                  udf_err;

  modport master (
    output flush, enqueue, wdata, dequeue,
    input  rdata, full, empty, almost_full, count, ovf_err, udf_err
  );

  modport slave (
    input  flush, enqueue, wdata, dequeue,
    output rdata, full, empty, almost_full, count, ovf_err, udf_err
  );
endinterface

// File: rtl/param_inst_queue.sv
// Parametrised first-word-fall-through circular queue for instruction/micro-op records,
// with synchronous flush, occupancy count and sticky overflow/underflow flags.
module param_inst_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int AF_THRESH  = DEPTH - 2
) (
  input logic                clk,
  input logic                rst,
  param_inst_queue_if.slave  q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         cnt;
  logic                  ovf;
  logic                  udf;
  logic                  is_full;
  logic                  is_empty;
  logic                  push_ok;
  logic                  pop_ok;

  assign is_full  = (cnt == CW'(DEPTH));
  assign is_empty = (cnt == '0);

  // A full queue still accepts a push when the same cycle pops; an empty queue never bypasses.
  assign push_ok = q.enqueue && (!is_full || q.dequeue);
  assign pop_ok  = q.dequeue && !is_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else if (q.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop_ok)  head <= head + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (q.enqueue && is_full && !q.dequeue) ovf <= 1'b1;
      if (q.dequeue && is_empty)              udf <= 1'b1;
    end
  end

  // Storage is intentionally not reset; stale contents are never visible while empty.
  always_ff @(posedge clk) begin
    if (!rst && !q.flush && push_ok) mem[tail] <= q.wdata;
  end

  assign q.rdata       = mem[head];
  assign q.full        = is_full;
  assign q.empty       = is_empty;
  assign q.almost_full = (cnt >= CW'(AF_THRESH));
  assign q.count       = cnt;
  assign q.ovf_err     = ovf;
  assign q.udf_err     = udf;
endmodule

// File: tb/tb_param_inst_queue.sv
// Self-checking bench for param_inst_queue (DEPTH=4, DATA_WIDTH=32, AF_THRESH=3).
module tb_param_inst_queue;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic clk;
  logic rst;

  param_inst_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) q ();

  param_inst_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk (clk),
    .rst (rst),
    .q   (q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard and reference status
  logic [DW-1:0] exp_q[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  task automatic check_status(input string tag);
    int n;
    n = exp_q.size();
    checks++;
    if (q.count !== 3'(n)) begin
      errors++; $display("FAIL %s count: got %0d want %0d", tag, q.count, n);
    end
    checks++;
    if (q.empty !== (n == 0) || q.full !== (n == DEPTH) || q.almost_full !== (n >= AF)) begin
      errors++;
      $display("FAIL %s flags e/f/af: got %b%b%b want %b%b%b", tag, q.empty, q.full,
               q.almost_full, n == 0, n == DEPTH, n >= AF);
    end
    checks++;
    if (q.ovf_err !== m_ovf || q.udf_err !== m_udf) begin
      errors++;
      $display("FAIL %s err ovf/udf: got %b%b want %b%b", tag, q.ovf_err, q.udf_err, m_ovf, m_udf);
    end
    if (n > 0) begin
      checks++;
      if (q.rdata !== exp_q[0]) begin
        errors++; $display("FAIL %s rdata head: got %h want %h", tag, q.rdata, exp_q[0]);
      end
    end
  endtask

  // driver: one clock of stimulus, scoreboard update, then post-edge status check
  task automatic cycle(input logic en, input logic [DW-1:0] d, input logic de,
                       input logic fl, input string tag);
    logic m_full, m_empty, push_ok, pop_ok;
    q.enqueue = en; q.wdata = d; q.dequeue = de; q.flush = fl;
    m_full  = (exp_q.size() == DEPTH);
    m_empty = (exp_q.size() == 0);
    push_ok = en && (!m_full || de);
    pop_ok  = de && !m_empty;
    if (fl) begin
      exp_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      if (pop_ok) begin
        checks++;
        if (q.rdata !== exp_q[0]) begin
          errors++; $display("FAIL %s pop data: got %h want %h", tag, q.rdata, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      if (push_ok) exp_q.push_back(d);
      if (en && m_full && !de) m_ovf = 1'b1;
      if (de && m_empty)       m_udf = 1'b1;
    end
    @(posedge clk); #1;
    q.enqueue = 1'b0; q.dequeue = 1'b0; q.flush = 1'b0;
    check_status(tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    q.enqueue = 1'b0; q.dequeue = 1'b0; q.flush = 1'b0; q.wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    check_status("reset");
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(32'hA0 + i), 1'b0, 1'b0, "fill");
  endtask

  task automatic test_push_pop_full();
    cycle(1'b1, 32'hBB, 1'b1, 1'b0, "push_pop_full");
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0, "drain_wrap");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom_range(255, 0)), 1'b0, 1'b0, "ovf_fill");
    cycle(1'b1, 32'hCC, 1'b0, 1'b0, "ovf_drop");
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0, "ovf_drain");
  endtask

  task automatic test_underflow();
    cycle(1'b1, 32'h11, 1'b1, 1'b0, "udf_push");
  endtask

  task automatic test_flush();
    while (exp_q.size() < 3) cycle(1'b1, DW'($urandom_range(255, 0)), 1'b0, 1'b0, "pre_flush");
    cycle(1'b1, 32'h99, 1'b1, 1'b1, "flush");
    cycle(1'b1, 32'h22, 1'b0, 1'b0, "post_flush_push");
    cycle(1'b0, '0, 1'b1, 1'b0, "post_flush_pop");
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 32'h31, 1'b0, 1'b0, "ar_fill");
    cycle(1'b1, 32'h32, 1'b0, 1'b0, "ar_fill");
    #2 rst = 1'b1;
    #1;
    exp_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    checks++;
    if (q.count !== 3'd0 || q.empty !== 1'b1 || q.full !== 1'b0 || q.almost_full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset outputs: got cnt=%0d e=%b f=%b af=%b want 0 1 0 0",
               q.count, q.empty, q.full, q.almost_full);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(32'h40 + i), 1'b0, 1'b0, "ar_after_push");
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, "ar_after_pop");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      cycle(1'($urandom_range(1, 0)), DW'($urandom), 1'($urandom_range(1, 0)),
            1'($urandom_range(15, 0) == 0), "random");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_push_pop_full();
    test_overflow();
    test_underflow();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
